multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath; successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction, stalls on a memory-ready handshake.
//  Adds addi, optional j, illegal-opcode trap. Sits between IR opcode field and datapath mux/enable pins.
// PARAMETERS
//  OPCODE_W  6   opcode field width
//  STATE_W   4   state register width (>= 4)
//  OP_RTYPE  0   R-type opcode;  OP_LW 35;  OP_SW 43;  OP_BEQ 4;  OP_ADDI 8;  OP_J 2
// PORTS
//  clk          in   1         rising-edge clock (only clock)
//  rst_n        in   1         synchronous, active-low reset
//  OPcode       in   OPCODE_W  IR[31:26], valid from DECODE onward
//  mem_ready    in   1         memory completes current access this cycle
//  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  out 1
//  ALUOp        out  2         00 add, 01 sub, 10 use funct
//  ALUSrcB      out  2         00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
//  PCSource     out  2         00 ALU, 01 ALUOut, 10 jump target
//  illegal_op   out  1         one-cycle pulse on undefined opcode
//  state_o      out  STATE_W   current state (debug)
// BEHAVIOUR
//  - Reset: rst_n=0 at posedge -> state=FETCH, illegal_op=0. Outputs are Moore decode of state, so post-reset
//    outputs = FETCH values: MemRead=1, ALUSrcB=01, ALUOp=00, IRWrite=PCWrite=mem_ready, all else 0.
//  - Reset dominates every other event, incl. mid-access wait states.
//  - States/encoding: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 RWB7 BEQ8 JUMP9 ADDIEX10 ADDIWB11.
//  - FETCH: MemRead,IorD=0,ALUSrcB=01; IRWrite/PCWrite only when mem_ready; stay until mem_ready=1 -> DECODE.
//  - DECODE: ALUSrcB=11, ALUOp=00. Next: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BEQ, ADDI->ADDIEX, J->JUMP;
//    else illegal_op=1 for exactly this cycle, -> FETCH.
//  - MEMADR: ALUSrcA=1,ALUSrcB=10. LW->MEMRD, SW->MEMWR.
//  - MEMRD: MemRead,IorD=1; hold until mem_ready -> MEMWB. MEMWB: RegWrite,MemtoReg=1,RegDst=0 -> FETCH.
//  - MEMWR: MemWrite,IorD=1; hold until mem_ready -> FETCH. MemWrite stays high for the whole wait.
//  - EXEC: ALUSrcA=1,ALUSrcB=00,ALUOp=10 -> RWB. RWB: RegWrite,RegDst=1,MemtoReg=0 -> FETCH.
//  - BEQ: ALUSrcA=1,ALUSrcB=00,ALUOp=01,PCWriteCond=1,PCSource=01 -> FETCH.
//  - ADDIEX: ALUSrcA=1,ALUSrcB=10,ALUOp=00 -> ADDIWB. ADDIWB: RegWrite,RegDst=0,MemtoReg=0 -> FETCH.
//  - JUMP: PCWrite=1,PCSource=10 -> FETCH.
//  - Latency (mem_ready tied 1): R 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles.
//  - Unused encodings 12..(2^STATE_W-1) -> FETCH next cycle, all outputs 0 there.
//  - OPcode sampled only in DECODE and MEMADR; changes elsewhere ignored.
// CONFIGURATION
//  MC_JUMP_EN defined: OP_J decodes to JUMP state as above.
//  MC_JUMP_EN undefined: JUMP state not built; OP_J treated as illegal (illegal_op pulse, -> FETCH).
// STRUCTURE
//  - Shared package mips_ctrl_pkg: state encodings, opcode constants, ALUOp/ALUSrcB/PCSource codes;
//    also used by the ALU control and the datapath muxes.
//  - One sub-module: mc_output_decode (pure combinational state+mem_ready -> control word). Next-state
//    logic and state register live in multicycle_control.
// TESTING
//  - Reset: rst_n=0 two cycles mid-MEMRD -> state_o=0, MemRead=1, RegWrite=0, illegal_op=0 next cycle.
//  - lw (OPcode=35), mem_ready=1: states 0,1,2,3,4,0; RegWrite=1 & MemtoReg=1 only in state 4.
//  - sw (43), mem_ready low 3 cycles in MEMWR: state 5 held 4 cycles, MemWrite=1 throughout, then 0.
//  - R-type (0) then beq (4): EXEC ALUOp=10, RWB RegDst=1; BEQ ALUOp=01, PCWriteCond=1, PCSource=01.
//  - addi (8): states 0,1,10,11,0; ALUSrcB=10 in 10; RegWrite=1, RegDst=0 in 11.
//  - OPcode=2 with/without MC_JUMP_EN: PCWrite=1,PCSource=10 in state 9 / illegal_op pulse, back to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encodings, opcodes and mux codes for the multi-cycle MIPS control path.
// Defining MC_JUMP_EN enables the j instruction (JUMP state); otherwise OP_J decodes as illegal.
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_COUNT  = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_J     = 6'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MC_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: Moore decode of the control state (plus mem_ready for fetch) into the datapath control word.
// The JUMP state drives outputs only when MC_JUMP_EN is defined.
module mc_output_decode
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic               mem_ready,
    output ctrl_t              ctrl
);

    always_comb begin
        ctrl = '0;
        if (state < STATE_W'(S_COUNT)) begin
            case (state[3:0])
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEMADR, S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_RWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BEQ: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_B;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = JUMP_EN;
                    ctrl.pc_source = JUMP_EN ? PCSRC_JUMP : PCSRC_ALU;
                end
                S_ADDIWB: ctrl.reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of the multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Build with MC_JUMP_EN defined to support j; without it OP_J raises illegal_op.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] OPcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                ALUSrcA,
    output logic                RegWrite,
    output logic                RegDst,
    output logic [1:0]          ALUOp,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic op_lw, op_sw, op_r, op_beq, op_addi, op_j;
    ctrl_t ctrl;

    function automatic logic [STATE_W-1:0] st(input logic [3:0] s);
        return STATE_W'(s);
    endfunction

    assign op_lw   = OPcode == OPCODE_W'(OP_LW);
    assign op_sw   = OPcode == OPCODE_W'(OP_SW);
    assign op_r    = OPcode == OPCODE_W'(OP_RTYPE);
    assign op_beq  = OPcode == OPCODE_W'(OP_BEQ);
    assign op_addi = OPcode == OPCODE_W'(OP_ADDI);
    assign op_j    = JUMP_EN && OPcode == OPCODE_W'(OP_J);

    // Encodings outside the defined set (and single-cycle states) fall back to FETCH.
    always_comb begin
        state_d    = st(S_FETCH);
        illegal_op = 1'b0;
        if (state_q < st(S_COUNT)) begin
            case (state_q[3:0])
                S_FETCH:  state_d = mem_ready ? st(S_DECODE) : state_q;
                S_DECODE: begin
                    state_d = (op_lw || op_sw) ? st(S_MEMADR) :
                              op_r             ? st(S_EXEC)   :
                              op_beq           ? st(S_BEQ)    :
                              op_addi          ? st(S_ADDIEX) :
                              op_j             ? st(S_JUMP)   : st(S_FETCH);
                    illegal_op = !(op_lw || op_sw || op_r || op_beq || op_addi || op_j);
                end
                S_MEMADR: state_d = op_lw ? st(S_MEMRD) : st(S_MEMWR);
                S_MEMRD:  state_d = mem_ready ? st(S_MEMWB) : state_q;
                S_MEMWR:  state_d = mem_ready ? st(S_FETCH) : state_q;
                S_EXEC:   state_d = st(S_RWB);
                S_ADDIEX: state_d = st(S_ADDIWB);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= rst_n ? state_d : st(S_FETCH);
    end

    mc_output_decode #(.STATE_W(STATE_W)) u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scoreboard bench for multicycle_control (state walk, stalls, reset, illegal/jump).
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] OPcode = 6'd0;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic       illegal_op;
    logic [3:0] state_o;
    logic [15:0] ctrl_vec;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int step_n = 0;

`ifdef MC_JUMP_EN
    localparam logic J_ILLEGAL = 1'b0;
`else
    localparam logic J_ILLEGAL = 1'b1;
`endif

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .OPcode      (OPcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    assign ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource};

    // Expected control word per state, written directly from the state table.
    function automatic logic [15:0] model(input int s, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rd;
        logic [1:0] aop, srcb, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rd} = '0;
        {aop, srcb, pcs} = '0;
        case (s)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rd, aop, srcb, pcs};
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic mr, input int s, input logic ill);
        exp_t e, got;
        @(negedge clk);
        rst_n = r;
        OPcode = op;
        mem_ready = mr;
        e.st = 4'(s);
        e.ctrl = model(s, mr);
        e.ill = ill;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        step_n++;
        checks++;
        assert (state_o === got.st) else begin
            errors++;
            $error("FAIL state step%0d: observed %0d expected %0d", step_n, state_o, got.st);
        end
        checks++;
        assert (ctrl_vec === got.ctrl) else begin
            errors++;
            $error("FAIL ctrl step%0d state%0d: observed %b expected %b", step_n, got.st, ctrl_vec, got.ctrl);
        end
        checks++;
        assert (illegal_op === got.ill) else begin
            errors++;
            $error("FAIL illegal_op step%0d: observed %b expected %b", step_n, illegal_op, got.ill);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        step(0, 35, 1, 0, 0);
        // lw, no stalls: 0,1,2,3,4
        step(1, 35, 1, 0, 0);
        step(1, 35, 1, 1, 0);
        step(1, 35, 1, 2, 0);
        step(1, 35, 1, 3, 0);
        step(1, 35, 1, 4, 0);
        // fetch stall
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 43, 1, 0, 0);
        // sw with three wait cycles in MEMWR
        step(1, 43, 1, 1, 0);
        step(1, 43, 1, 2, 0);
        step(1, 43, 0, 5, 0);
        step(1, 43, 0, 5, 0);
        step(1, 43, 0, 5, 0);
        step(1, 43, 1, 5, 0);
        // R-type; opcode change in EXEC must be ignored
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 35, 1, 6, 0);
        step(1, 35, 1, 7, 0);
        // beq
        step(1, 4, 1, 0, 0);
        step(1, 4, 1, 1, 0);
        step(1, 4, 1, 8, 0);
        // addi
        step(1, 8, 1, 0, 0);
        step(1, 8, 1, 1, 0);
        step(1, 8, 1, 10, 0);
        step(1, 8, 1, 11, 0);
        // j: jump state when enabled, illegal pulse otherwise
        step(1, 2, 1, 0, 0);
        step(1, 2, 1, 1, J_ILLEGAL);
`ifdef MC_JUMP_EN
        step(1, 2, 1, 9, 0);
`endif
        // undefined opcode
        step(1, 63, 1, 0, 0);
        step(1, 63, 1, 1, 1);
        // reset held two cycles while waiting in MEMRD
        step(1, 35, 1, 0, 0);
        step(1, 35, 1, 1, 0);
        step(1, 35, 1, 2, 0);
        step(1, 35, 0, 3, 0);
        step(0, 35, 0, 3, 0);
        step(0, 35, 0, 0, 0);
        step(1, 35, 1, 0, 0);
        step(1, 35, 1, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
